// File: rtl/byte_serializer.sv
// byte_serializer: parallel words out as an LSB-first bit stream with one write strobe per bit.
// Optional one-word holding register, enabled by defining BYTE_SERIALIZER_BUFFER_EN.
module byte_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int WR_HIGH_CYCLES = 10,
  parameter int WR_LOW_CYCLES  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  input  logic                  status_in,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy_out
);
  localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int MAX_CYC = (WR_HIGH_CYCLES > WR_LOW_CYCLES) ? WR_HIGH_CYCLES : WR_LOW_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] HI_LAST  = CNT_W'(WR_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(WR_LOW_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, SETUP, STROBE_HI, STROBE_LO} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic                  data_q, data_d;
  logic                  write_q, write_d;
  logic                  ready_q, ready_d;
  logic [1:0]            sync_q, sync_d;
  logic                  accept;
  logic                  word_done;
`ifdef BYTE_SERIALIZER_BUFFER_EN
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
`endif

  assign accept         = byte_valid_in && ready_q;
  assign byte_ready_out = ready_q;
  assign data_out       = data_q;
  assign write_out      = write_q;
  assign busy_out       = (state_q != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    data_d    = data_q;
    write_d   = write_q;
    word_done = 1'b0;
    // status_in is asynchronous to clock; only sync_q[1] is used by the FSM.
    sync_d    = {sync_q[0], status_in};
`ifdef BYTE_SERIALIZER_BUFFER_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d   = byte_in;
          bit_cnt_d = '0;
          state_d   = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (sync_q[1]) begin
          data_d  = shift_q[0];
          state_d = SETUP;
        end
      end
      SETUP: begin
        write_d   = 1'b1;
        cyc_cnt_d = '0;
        state_d   = STROBE_HI;
      end
      STROBE_HI: begin
        if (cyc_cnt_q == HI_LAST) begin
          write_d   = 1'b0;
          cyc_cnt_d = '0;
          shift_d   = shift_q >> 1;
          // The last bit stays on data_out until the next word's setup.
          if (bit_cnt_q != BIT_LAST) data_d = shift_d[0];
          state_d   = STROBE_LO;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      STROBE_LO: begin
        if (cyc_cnt_q == LO_LAST) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            write_d   = 1'b1;
            state_d   = STROBE_HI;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef BYTE_SERIALIZER_BUFFER_EN
    if (word_done) begin
      if (hold_full_q) begin
        shift_d     = hold_q;
        bit_cnt_d   = '0;
        hold_full_d = 1'b0;
        state_d     = WAIT_RDY;
      end else begin
        state_d = IDLE;
      end
    end
    // Outside IDLE an accepted word parks in the holding register.
    if (accept && (state_q != IDLE)) begin
      hold_d      = byte_in;
      hold_full_d = 1'b1;
    end
    ready_d = !hold_full_d;
`else
    if (word_done) state_d = IDLE;
    ready_d = (state_d == IDLE);
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      data_q    <= 1'b0;
      write_q   <= 1'b0;
      ready_q   <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      data_q    <= data_d;
      write_q   <= write_d;
      ready_q   <= ready_d;
      sync_q    <= sync_d;
    end
  end

`ifdef BYTE_SERIALIZER_BUFFER_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end
`endif

endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench for byte_serializer: vector table of words plus hand-written reset,
// back-to-back and fast-strobe sequences.
module tb_byte_serializer;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid_in, status_in;
  logic       byte_ready_out, data_out, write_out, busy_out;
  logic [7:0] f_byte;
  logic       f_valid, f_status, f_ready, f_data, f_write, f_busy;

`ifdef BYTE_SERIALIZER_BUFFER_EN
  localparam bit BUFFERED = 1'b1;
`else
  localparam bit BUFFERED = 1'b0;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_w = 1'b0;
  int   rdy_bad = 0;
  int   rise_t[$];
  logic pulse_bit[$];
  int   hi_len[$];
  logic pulse_bad[$];

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [0:7] bits;
    int         raise_at;
    int         drop_at;
    int         first_off;
  } vec_t;
  vec_t vecs[5];

  int   acc, acc1, acc2, done, k;
  int   nrise, nhigh, first, hi_bad, idle_at;
  logic pw;

  always #5 clock = ~clock;

  byte_serializer #(.DATA_WIDTH(8), .WR_HIGH_CYCLES(10), .WR_LOW_CYCLES(10)) u_dut (
    .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .byte_ready_out(byte_ready_out), .status_in(status_in), .data_out(data_out),
    .write_out(write_out), .busy_out(busy_out)
  );

  byte_serializer #(.DATA_WIDTH(8), .WR_HIGH_CYCLES(1), .WR_LOW_CYCLES(1)) u_fast (
    .clock(clock), .reset(reset), .byte_in(f_byte), .byte_valid_in(f_valid),
    .byte_ready_out(f_ready), .status_in(f_status), .data_out(f_data),
    .write_out(f_write), .busy_out(f_busy)
  );

  // Pulse recorder for u_dut: rise cycle, bit on the pulse, high length, data stability.
  always @(posedge clock) begin
    #1;
    cyc = cyc + 1;
    if (write_out && !prev_w) begin
      rise_t.push_back(cyc);
      pulse_bit.push_back(data_out);
      hi_len.push_back(1);
      pulse_bad.push_back(1'b0);
    end else if (write_out && rise_t.size() > 0) begin
      hi_len[hi_len.size()-1] += 1;
      if (data_out != pulse_bit[pulse_bit.size()-1]) pulse_bad[pulse_bad.size()-1] = 1'b1;
    end
    prev_w = write_out;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rise_t.delete();
    pulse_bit.delete();
    hi_len.delete();
    pulse_bad.delete();
    rdy_bad = 0;
  endtask

  task automatic send(input logic [7:0] b, output int acc_o);
    int n = 0;
    while (!byte_ready_out && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (!byte_ready_out) check("send_ready_timeout", 0, 1);
    byte_in       = b;
    byte_valid_in = 1'b1;
    @(negedge clock);
    acc_o         = cyc;
    byte_valid_in = 1'b0;
  endtask

  task automatic wait_done(input int acc_i, input int raise_at, input int drop_at, output int done_o);
    int n = 0;
    while (busy_out && n < 2000) begin
      if (cyc - acc_i == raise_at) status_in = 1'b1;
      if (cyc - acc_i == drop_at) status_in = 1'b0;
      if (!BUFFERED && byte_ready_out) rdy_bad = 1;
      @(negedge clock);
      n++;
    end
    if (busy_out) check("done_timeout", 0, 1);
    done_o = cyc;
  endtask

  task automatic check_word(input string name, input logic [0:15] bits, input int n,
                            input int first_abs, input int done_act, input int done_exp);
    check($sformatf("%s_pulses", name), rise_t.size(), n);
    check($sformatf("%s_ready_low", name), rdy_bad, 0);
    if (rise_t.size() >= n) begin
      check($sformatf("%s_first_rise", name), rise_t[0], first_abs);
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_bit%0d", name, i), pulse_bad[i] ? 2 : int'(pulse_bit[i]), int'(bits[i]));
        check($sformatf("%s_high%0d", name, i), hi_len[i], 10);
        if (i % 8 != 0) check($sformatf("%s_period%0d", name, i), rise_t[i] - rise_t[i-1], 20);
      end
    end
    check($sformatf("%s_done", name), done_act, done_exp);
  endtask

  task automatic run_vec(input vec_t v);
    int a, d;
    status_in = (v.raise_at < 0);
    repeat (4) @(negedge clock);
    clear_mon();
    send(v.data, a);
    wait_done(a, v.raise_at, v.drop_at, d);
    check_word(v.name, {v.bits, 8'h00}, 8, a + v.first_off, d - a, v.first_off + 160);
  endtask

  initial begin
    // Expected bits listed in pulse order (LSB of the word first).
    vecs[0] = '{"w99",       8'h99, 8'b10011001, -1, -1,  2};
    vecs[1] = '{"wA5_wait",  8'hA5, 8'b10100101, 50, -1, 54};
    vecs[2] = '{"w0F_drop",  8'h0F, 8'b11110000, -1, 45,  2};
    vecs[3] = '{"w00",       8'h00, 8'b00000000, -1, -1,  2};
    vecs[4] = '{"w80_late",  8'h80, 8'b00000001,  0, -1,  4};

    // Reset held with input activity.
    reset = 1'b0; byte_in = 8'hA5; byte_valid_in = 1'b1; status_in = 1'b1;
    f_byte = 8'h5A; f_valid = 1'b1; f_status = 1'b1;
    repeat (5) begin
      @(negedge clock);
      byte_in = ~byte_in; status_in = ~status_in; f_byte = ~f_byte;
    end
    check("rst_data", data_out, 0);
    check("rst_write", write_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_ready", byte_ready_out, 0);
    check("rst_fast_ready", f_ready, 0);
    byte_valid_in = 1'b0; f_valid = 1'b0; status_in = 1'b1; f_status = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready_at_release", byte_ready_out, 0);
    @(negedge clock);
    check("ready_one_edge_after", byte_ready_out, 1);
    check("busy_after_release", busy_out, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Reset during the 4th pulse of 0x0F, then a clean 0x3C.
    status_in = 1'b1;
    repeat (4) @(negedge clock);
    clear_mon();
    send(8'h0F, acc);
    repeat (65) @(negedge clock);
    check("midrst_pulse_count", rise_t.size(), 4);
    check("midrst_write_before", write_out, 1);
    reset = 1'b0;
    #1;
    check("midrst_write", write_out, 0);
    check("midrst_data", data_out, 0);
    check("midrst_busy", busy_out, 0);
    check("midrst_ready", byte_ready_out, 0);
    @(negedge clock);
    reset = 1'b1;
    run_vec('{"w3C_after_rst", 8'h3C, 8'b00111100, -1, -1, 2});

    // Back-to-back 0x01 then 0xFE.
    status_in = 1'b1;
    repeat (4) @(negedge clock);
    clear_mon();
    send(8'h01, acc1);
    byte_in = 8'hFE; byte_valid_in = 1'b1;
    check("b2b_ready_during_shift", byte_ready_out, BUFFERED ? 1 : 0);
    acc2 = -1; k = 0;
    while (byte_valid_in && k < 1000) begin
      if (byte_ready_out) begin
        @(negedge clock);
        acc2 = cyc;
        byte_valid_in = 1'b0;
      end else begin
        @(negedge clock);
        k++;
      end
    end
    byte_valid_in = 1'b0;
    check("b2b_accept_offset", acc2 - acc1, BUFFERED ? 1 : 163);
    wait_done(acc2, -1, -1, done);
    if (rise_t.size() > 8) check("b2b_second_rise", rise_t[8] - acc1, BUFFERED ? 164 : 165);
    check_word("b2b", 16'b10000000_01111111, 16, acc1 + 2, done - acc1, BUFFERED ? 324 : 325);

    // One-cycle strobes on the fast instance.
    k = 0;
    while (!f_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    f_byte = 8'hFF; f_valid = 1'b1;
    @(negedge clock);
    f_valid = 1'b0;
    nrise = 0; nhigh = 0; first = -1; hi_bad = 0; idle_at = -1; pw = 1'b0;
    for (int off = 1; off <= 22; off++) begin
      @(negedge clock);
      if (f_write && !pw) begin
        nrise++;
        if (first < 0) first = off;
      end
      if (f_write) nhigh++;
      if (f_write && !f_data) hi_bad++;
      if (!f_busy && idle_at < 0) idle_at = off;
      pw = f_write;
    end
    check("fast_pulses", nrise, 8);
    check("fast_high_cycles", nhigh, 8);
    check("fast_first_rise", first, 2);
    check("fast_data_high", hi_bad, 0);
    check("fast_done", idle_at, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
